// File: rtl/id_frame_packer.sv
// id_frame_packer: collects a 10-char ASCII ID, validates and maps it,
// replays it as a 6-bit burst to the ID checker and merges the verdict.
module id_frame_packer #(
  parameter int WAIT_MAX = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  output logic       id_valid,
  output logic [5:0] id_code,
  input  logic       chk_valid,
  input  logic       chk_legal,
  output logic       res_valid,
  output logic       res_legal,
  output logic       res_fmt_err,
  output logic       res_timeout
);

  typedef enum logic [1:0] {
    COLLECT,
    SEND,
    WAIT,
    REPORT
  } state_t;

  localparam logic [7:0] WMAX = 8'(WAIT_MAX);

  state_t     state;
  logic [3:0] idx;
  logic [5:0] frame_buf [10];
  logic       fmt_err;
  logic [7:0] cnt;

  logic       is_upper;
  logic       is_digit;
  logic       bad_char;
  logic       accept;
  logic [5:0] char_code;

  function automatic logic [5:0] letter_code(input logic [7:0] c);
    logic [5:0] code;
    case (c)
      "A": code = 6'd10;
      "B": code = 6'd11;
      "C": code = 6'd12;
      "D": code = 6'd13;
      "E": code = 6'd14;
      "F": code = 6'd15;
      "G": code = 6'd16;
      "H": code = 6'd17;
      "I": code = 6'd34;
      "J": code = 6'd18;
      "K": code = 6'd19;
      "L": code = 6'd20;
      "M": code = 6'd21;
      "N": code = 6'd22;
      "O": code = 6'd35;
      "P": code = 6'd23;
      "Q": code = 6'd24;
      "R": code = 6'd25;
      "S": code = 6'd26;
      "T": code = 6'd27;
      "U": code = 6'd28;
      "V": code = 6'd29;
      "W": code = 6'd32;
      "X": code = 6'd30;
      "Y": code = 6'd31;
      "Z": code = 6'd33;
      default: code = 6'd0;
    endcase
    return code;
  endfunction

  always_comb begin
    is_upper  = (ch_data >= 8'h41) && (ch_data <= 8'h5A);
    is_digit  = (ch_data >= 8'h30) && (ch_data <= 8'h39);
    bad_char  = (idx == 4'd0) ? !is_upper : !is_digit;
    char_code = (idx == 4'd0) ? letter_code(ch_data)
                              : {2'b00, ch_data[3:0]};
    accept    = ch_valid && ch_ready && (state == COLLECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      idx         <= 4'd0;
      fmt_err     <= 1'b0;
      cnt         <= 8'd0;
      ch_ready    <= 1'b1;
      id_valid    <= 1'b0;
      id_code     <= 6'd0;
      res_valid   <= 1'b0;
      res_legal   <= 1'b0;
      res_fmt_err <= 1'b0;
      res_timeout <= 1'b0;
      for (int i = 0; i < 10; i++) frame_buf[i] <= 6'd0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (accept) begin
            frame_buf[idx] <= char_code;
            if (idx == 4'd9) begin
              ch_ready <= 1'b0;
              if (fmt_err || bad_char) begin
                state       <= REPORT;
                res_valid   <= 1'b1;
                res_fmt_err <= 1'b1;
                idx         <= 4'd0;
              end else begin
                // letter code leaves on the same edge as the last accept
                state    <= SEND;
                id_valid <= 1'b1;
                id_code  <= frame_buf[0];
                idx      <= 4'd1;
              end
            end else begin
              fmt_err <= fmt_err || bad_char;
              idx     <= idx + 4'd1;
            end
          end
        end
        SEND: begin
          if (idx == 4'd10) begin
            state    <= WAIT;
            id_valid <= 1'b0;
            id_code  <= 6'd0;
            idx      <= 4'd0;
            cnt      <= 8'd0;
          end else begin
            id_code <= frame_buf[idx];
            idx     <= idx + 4'd1;
          end
        end
        WAIT: begin
          if (chk_valid) begin
            state     <= REPORT;
            res_valid <= 1'b1;
            res_legal <= chk_legal;
          end else if (cnt == WMAX) begin
            state       <= REPORT;
            res_valid   <= 1'b1;
            res_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        REPORT: begin
          state       <= COLLECT;
          ch_ready    <= 1'b1;
          res_valid   <= 1'b0;
          res_legal   <= 1'b0;
          res_fmt_err <= 1'b0;
          res_timeout <= 1'b0;
          idx         <= 4'd0;
          fmt_err     <= 1'b0;
          cnt         <= 8'd0;
        end
      endcase
    end
  end

endmodule
